// File: rtl/subtractor16_brent_kung_pipe_pkg.sv
// Shared arithmetic package for the Brent-Kung adder/subtractor family.
// Holds the datapath width, prefix depth and the generate/propagate pair type.
package subtractor16_brent_kung_pipe_pkg;

   localparam int N            = 16;
   localparam int PREFIX_DEPTH = 4;

   typedef struct packed {
      logic g;
      logic p;
   } gp_pair_t;

endpackage

// File: rtl/subtractor16_brent_kung_pipe_bk_gp_node.sv
// Brent-Kung prefix operator cell: combines a high and a low group.
// Ports: hi_i (upper group g/p), lo_i (lower group g/p), gp_o (merged group).
module bk_gp_node
   import subtractor16_brent_kung_pipe_pkg::*;
(
   input  gp_pair_t hi_i,
   input  gp_pair_t lo_i,
   output gp_pair_t gp_o
);

   assign gp_o.g = hi_i.g | (hi_i.p & lo_i.g);
   assign gp_o.p = hi_i.p & lo_i.p;

endmodule

// File: rtl/subtractor16_brent_kung_pipe.sv
// 3-stage pipelined 16-bit subtractor (Z = X - Y - BorrowIn), Brent-Kung borrow tree.
// Ports: clk/reset; iValid/oReady in; iX/iY/iBorrowIn; oValid/iReady out;
//        oZ difference; oBorrowOut, oOverflow, oZero flags.
module subtractor16_brent_kung_pipe #(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         iValid,
   output logic         oReady,
   input  logic [N-1:0] iX,
   input  logic [N-1:0] iY,
   input  logic         iBorrowIn,
   output logic         oValid,
   input  logic         iReady,
   output logic [N-1:0] oZ,
   output logic         oBorrowOut,
   output logic         oOverflow,
   output logic         oZero
);

   import subtractor16_brent_kung_pipe_pkg::*;

   // ---------------- handshake / stage enables ----------------
   logic en1, en2, en3;
   logic v1_q, v2_q, v3_q;
   logic v1_d, v2_d, v3_d;

   always_comb begin
      en3    = ~v3_q | iReady;
      en2    = ~v2_q | en3;
      en1    = ~v1_q | en2;
      oReady = en1 & ~reset;
      v1_d   = iValid & oReady;
      v2_d   = v1_q;
      v3_d   = v2_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
      end else begin
         if (en1) v1_q <= v1_d;
         if (en2) v2_q <= v2_d;
         if (en3) v3_q <= v3_d;
      end
   end

   // ---------------- S1: operands, Y inverted, c0 = ~borrow ----------------
   logic [N-1:0] x1_q, ny1_q;
   logic [N-1:0] ny1_d;
   logic         c01_q, c01_d;

   assign ny1_d = ~iY;
   assign c01_d = ~iBorrowIn;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x1_q  <= '0;
         ny1_q <= '0;
         c01_q <= 1'b0;
      end else if (en1) begin
         x1_q  <= iX;
         ny1_q <= ny1_d;
         c01_q <= c01_d;
      end
   end

   // ---------------- S1 -> S2: bit g/p, up-sweep spans 2 and 4 ----------------
   gp_pair_t [N-1:0] l0, l1, l2;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         l0[i].g = x1_q[i] & ny1_q[i];
         l0[i].p = x1_q[i] ^ ny1_q[i];
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_l1
      if (i % 2 == 1) begin : g_node
         bk_gp_node u_node (.hi_i(l0[i]), .lo_i(l0[i-1]), .gp_o(l1[i]));
      end else begin : g_pass
         assign l1[i] = l0[i];
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_l2
      if (i % 4 == 3) begin : g_node
         bk_gp_node u_node (.hi_i(l1[i]), .lo_i(l1[i-2]), .gp_o(l2[i]));
      end else begin : g_pass
         assign l2[i] = l1[i];
      end
   end

   // ---------------- S2: partial prefix, raw p, c0 ----------------
   gp_pair_t [N-1:0] gp2_q;
   logic     [N-1:0] p2_q, p2_d;
   logic             c02_q;

   always_comb begin
      for (int i = 0; i < N; i++) p2_d[i] = l0[i].p;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gp2_q <= '0;
         p2_q  <= '0;
         c02_q <= 1'b0;
      end else if (en2) begin
         gp2_q <= l2;
         p2_q  <= p2_d;
         c02_q <= c01_q;
      end
   end

   // ---------------- S2 -> S3: up-sweep spans 8/16, then inverse tree ----------------
   gp_pair_t [N-1:0] l3, l4, l5, l6, l7;

   for (genvar i = 0; i < N; i++) begin : g_l3
      if (i % 8 == 7) begin : g_node
         bk_gp_node u_node (.hi_i(gp2_q[i]), .lo_i(gp2_q[i-4]), .gp_o(l3[i]));
      end else begin : g_pass
         assign l3[i] = gp2_q[i];
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_l4
      if (i % 16 == 15) begin : g_node
         bk_gp_node u_node (.hi_i(l3[i]), .lo_i(l3[i-8]), .gp_o(l4[i]));
      end else begin : g_pass
         assign l4[i] = l3[i];
      end
   end

   // Inverse tree fills positions not finished by the up-sweep: 11, then 5/9/13, then evens.
   for (genvar i = 0; i < N; i++) begin : g_l5
      if ((i % 8 == 3) && (i >= 8)) begin : g_node
         bk_gp_node u_node (.hi_i(l4[i]), .lo_i(l4[i-4]), .gp_o(l5[i]));
      end else begin : g_pass
         assign l5[i] = l4[i];
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_l6
      if ((i % 4 == 1) && (i >= 4)) begin : g_node
         bk_gp_node u_node (.hi_i(l5[i]), .lo_i(l5[i-2]), .gp_o(l6[i]));
      end else begin : g_pass
         assign l6[i] = l5[i];
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_l7
      if ((i % 2 == 0) && (i >= 2)) begin : g_node
         bk_gp_node u_node (.hi_i(l6[i]), .lo_i(l6[i-1]), .gp_o(l7[i]));
      end else begin : g_pass
         assign l7[i] = l6[i];
      end
   end

   // l7[i] now spans [i:0]; c0 acts as the group below bit 0.
   logic [N:0]   c;
   logic [N-1:0] z3_d;
   logic         b3_d, o3_d, zr3_d;

   always_comb begin
      c[0] = c02_q;
      for (int i = 0; i < N; i++) begin
         c[i+1] = l7[i].g | (l7[i].p & c02_q);
      end
      z3_d  = p2_q ^ c[N-1:0];
      b3_d  = ~c[N];
      // Same as (X15 != Y15) & (Z15 != X15) for the X + ~Y + c0 form.
      o3_d  = c[N] ^ c[N-1];
      zr3_d = ~|z3_d;
   end

   // ---------------- S3: result and flags ----------------
   logic [N-1:0] z3_q;
   logic         b3_q, o3_q, zr3_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         z3_q  <= '0;
         b3_q  <= 1'b0;
         o3_q  <= 1'b0;
         zr3_q <= 1'b0;
      end else if (en3) begin
         z3_q  <= z3_d;
         b3_q  <= b3_d;
         o3_q  <= o3_d;
         zr3_q <= zr3_d;
      end
   end

   assign oValid     = v3_q;
   assign oZ         = z3_q;
   assign oBorrowOut = b3_q;
   assign oOverflow  = o3_q;
   assign oZero      = zr3_q;

endmodule
